serial_frame_feeder: RTL and testbench



---
 rtl/seq_link_pkg.sv | 24 ++
 rtl/serial_frame_feeder_if.sv | 14 +
 rtl/serial_frame_feeder_piso_shift_reg.sv | 29 ++
 rtl/serial_frame_feeder.sv | 126 ++++++++++++
 tb/tb_serial_frame_feeder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial link blocks: FSM encoding, parameter bounds
// and the even-parity helper.
package seq_link_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MAX   = 255;

    // Even parity over a zero-extended word: XOR of all bits.
    function automatic logic even_parity(input logic [WIDTH_MAX-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/serial_frame_feeder_if.sv
// Parallel word handshake into the serial frame feeder.
interface serial_frame_feeder_if #(
    parameter int WIDTH = 8
);
    // A word transfers on the rising clk edge where data_valid && data_ready are
    // both high; the producer holds data_in and data_valid stable until then.
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/serial_frame_feeder_piso_shift_reg.sv
// Parallel-in serial-out register; the head bit is a flop output and the
// register drains to zero, so the head reads 0 once a frame is finished.
module piso_shift_reg #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift_en,
    input  logic [N-1:0] load_data,
    output logic         head
);

    logic [N-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= (MSB_FIRST != 0) ? {q[N-2:0], 1'b0} : {1'b0, q[N-1:1]};
        end
    end

    assign head = (MSB_FIRST != 0) ? q[N-1] : q[0];

endmodule

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial frame feeder: accepts a word on a valid/ready handshake and
// emits it one bit per clock. Define SER_FEEDER_PARITY_EN to append an even-parity bit.
module serial_frame_feeder
    import seq_link_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_frame_feeder_if.slave link,
    output logic                 serial_out,
    output logic                 serial_valid,
    output logic                 frame_done,
    output logic                 busy,
    output state_t               fsm_state
);

`ifdef SER_FEEDER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = WIDTH + PARITY_BITS;
    localparam int CNT_W      = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_frame_feeder: WIDTH out of legal range");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
        $error("serial_frame_feeder: GAP_CYCLES out of legal range");
    end

    state_t                 state, state_next;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
    logic [7:0]             gap_cnt, gap_cnt_next;
    logic                   load, shift_en;
    logic [FRAME_BITS-1:0]  load_word;

    // Parity sits after the data in send order, at the tail of the shift direction.
`ifdef SER_FEEDER_PARITY_EN
    logic par;
    assign par       = even_parity(WIDTH_MAX'(link.data_in));
    assign load_word = (MSB_FIRST != 0) ? {link.data_in, par} : {par, link.data_in};
`else
    assign load_word = link.data_in;
`endif

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        load         = 1'b0;
        shift_en     = 1'b0;
        case (state)
            IDLE: begin
                if (link.data_valid) begin
                    load         = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_next = '0;
                    state_next   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
                gap_cnt_next = '0;
            end
        endcase
    end

    // Status outputs are registered from the next-state values so they line up
    // with the bit leaving the shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            serial_valid <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            gap_cnt      <= gap_cnt_next;
            serial_valid <= (state_next == SHIFT);
            frame_done   <= (state_next == SHIFT) && (bit_cnt_next == LAST_BIT);
            busy         <= (state_next != IDLE);
        end
    end

    piso_shift_reg #(
        .N         (FRAME_BITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (load_word),
        .head      (serial_out)
    );

    assign link.data_ready = (state == IDLE);
    assign fsm_state       = state;

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: two instances (MSB-first/no gap, LSB-first/gap 3)
// share one producer and are checked every cycle against a frame-level model.
module tb_serial_frame_feeder;
    import seq_link_pkg::*;

`ifdef SER_FEEDER_PARITY_EN
    localparam int FB = 9;
    localparam logic [FB-1:0] EXP_D3_A = 9'h1A7;
    localparam logic [FB-1:0] EXP_D3_B = 9'h197;
    localparam logic [FB-1:0] EXP_01_A = 9'h003;
    localparam logic [FB-1:0] EXP_01_B = 9'h101;
    localparam logic [FB-1:0] EXP_0F_A = 9'h01E;
    localparam logic [FB-1:0] EXP_0F_B = 9'h1E0;
`else
    localparam int FB = 8;
    localparam logic [FB-1:0] EXP_D3_A = 8'hD3;
    localparam logic [FB-1:0] EXP_D3_B = 8'hCB;
    localparam logic [FB-1:0] EXP_01_A = 8'h01;
    localparam logic [FB-1:0] EXP_01_B = 8'h80;
    localparam logic [FB-1:0] EXP_0F_A = 8'h0F;
    localparam logic [FB-1:0] EXP_0F_B = 8'hF0;
`endif
    localparam int GAP_B = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] din;
    logic       dv;
    logic       so_a, sv_a, fd_a, bz_a, rdy_a;
    logic       so_b, sv_b, fd_b, bz_b, rdy_b;
    state_t     st_a, st_b;

    serial_frame_feeder_if #(.WIDTH(8)) bus_a ();
    serial_frame_feeder_if #(.WIDTH(8)) bus_b ();
    assign bus_a.data_in    = din;
    assign bus_a.data_valid = dv;
    assign bus_b.data_in    = din;
    assign bus_b.data_valid = dv;
    assign rdy_a = bus_a.data_ready;
    assign rdy_b = bus_b.data_ready;

    serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .link(bus_a.slave),
        .serial_out(so_a), .serial_valid(sv_a), .frame_done(fd_a), .busy(bz_a),
        .fsm_state(st_a)
    );

    serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .link(bus_b.slave),
        .serial_out(so_b), .serial_valid(sv_b), .frame_done(fd_b), .busy(bz_b),
        .fsm_state(st_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Per instance: the accepted frame (first bit at the top), bits still to send,
    // and cycles until the instance is ready again.
    logic [FB-1:0] mframe [2];
    int            mleft  [2];
    int            mrem   [2];

    function automatic logic [FB-1:0] frame_bits(input logic [7:0] w, input bit msb);
        logic [FB-1:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[FB-1-k] = msb ? w[7-k] : w[k];
`ifdef SER_FEEDER_PARITY_EN
        f[0] = ^w;
`endif
        return f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int id = 0; id < 2; id++) begin
            if (!reset_n) begin
                mleft[id] <= 0;
                mrem[id]  <= 0;
            end else if (mrem[id] == 0 && dv) begin
                mframe[id] <= frame_bits(din, id == 0);
                mleft[id]  <= FB;
                mrem[id]   <= FB + ((id == 0) ? 0 : GAP_B);
            end else begin
                if (mleft[id] > 0) mleft[id] <= mleft[id] - 1;
                if (mrem[id] > 0)  mrem[id]  <= mrem[id] - 1;
            end
        end
    end

    task automatic check_dut(input int id, input logic so, input logic sv, input logic fd,
                             input logic bz, input logic rdy);
        int    l;
        string n;
        l = mleft[id];
        n = (id == 0) ? "a" : "b";
        check({n, " serial_valid"}, sv, l > 0);
        check({n, " serial_out"}, so, (l > 0) ? mframe[id][l-1] : 1'b0);
        check({n, " frame_done"}, fd, l == 1);
        check({n, " busy"}, bz, mrem[id] > 0);
        check({n, " data_ready"}, rdy, mrem[id] == 0);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check_dut(0, so_a, sv_a, fd_a, bz_a, rdy_a);
        check_dut(1, so_b, sv_b, fd_b, bz_b, rdy_b);
    end

    // ---------------- driver tasks ----------------
    task automatic run_frame(input logic [7:0] w, output logic [FB-1:0] ca, output logic [FB-1:0] cb,
                             output int nva, output int done_at, output int ra, output int rb);
        ca = '0; cb = '0; nva = 0; done_at = 0; ra = 0; rb = 0;
        @(negedge clk);
        din = w;
        dv  = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            din = 8'($urandom);
            if (sv_a) begin
                ca = {ca[FB-2:0], so_a};
                nva++;
            end
            if (sv_b) cb = {cb[FB-2:0], so_b};
            if (fd_a && done_at == 0) done_at = c;
            if (rdy_a && ra == 0) ra = c;
            if (rdy_b && rb == 0) rb = c;
            if (ra != 0 && rb != 0) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rdy_a && rdy_b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle timeout", 32'(rdy_a && rdy_b), 32'd1);
    endtask

    logic [FB-1:0] ca, cb;
    int nva, done_at, ra, rb;
    int ta[2], tb[2];
    int na, nb;

    initial begin
        reset_n = 1'b0;
        dv      = 1'b0;
        din     = '0;
        repeat (3) @(negedge clk);
        check("reset serial_out", so_a, 1'b0);
        check("reset serial_valid", sv_a, 1'b0);
        check("reset frame_done", fd_a, 1'b0);
        check("reset busy", bz_a, 1'b0);
        check("reset data_ready", rdy_a, 1'b1);
        check("reset state", 32'(st_a), 32'(IDLE));
        check("reset b data_ready", rdy_b, 1'b1);
        reset_n = 1'b1;

        run_frame(8'hD3, ca, cb, nva, done_at, ra, rb);
        check("D3 a bits", 32'(ca), 32'(EXP_D3_A));
        check("D3 b bits", 32'(cb), 32'(EXP_D3_B));
        check("D3 a valid count", nva, FB);
        check("D3 a frame_done cycle", done_at, FB);
        check("D3 a ready again", ra, FB + 1);
        check("D3 b ready again", rb, FB + 1 + GAP_B);

        run_frame(8'h01, ca, cb, nva, done_at, ra, rb);
        check("01 a bits", 32'(ca), 32'(EXP_01_A));
        check("01 b bits", 32'(cb), 32'(EXP_01_B));
        check("01 b ready again", rb, FB + 1 + GAP_B);

        // Back-to-back: data_valid held high, A5 then 5A.
        na = 0; nb = 0;
        ta[0] = 0; ta[1] = 0; tb[0] = 0; tb[1] = 0;
        @(negedge clk);
        din = 8'hA5;
        dv  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (na >= 1) din = 8'h5A;
            if (rdy_a && na < 2) begin ta[na] = c; na++; end
            if (rdy_b && nb < 2) begin tb[nb] = c; nb++; end
            if (na == 2 && nb == 2) break;
            @(negedge clk);
        end
        dv = 1'b0;
        check("b2b a accepts", na, 2);
        check("b2b b accepts", nb, 2);
        check("b2b a period", ta[1] - ta[0], FB + 1);
        check("b2b b period", tb[1] - tb[0], FB + 1 + GAP_B);
        wait_idle();

        // Reset after three bits of FF.
        @(negedge clk);
        din = 8'hFF;
        dv  = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset a serial_valid", sv_a, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset a serial_valid", sv_a, 1'b0);
        check("midreset a serial_out", so_a, 1'b0);
        check("midreset a data_ready", rdy_a, 1'b1);
        check("midreset a busy", bz_a, 1'b0);
        check("midreset b serial_valid", sv_b, 1'b0);
        check("midreset b data_ready", rdy_b, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(8'h0F, ca, cb, nva, done_at, ra, rb);
        check("0F a bits", 32'(ca), 32'(EXP_0F_A));
        check("0F b bits", 32'(cb), 32'(EXP_0F_B));
        check("0F a valid count", nva, FB);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            dv  = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
        end
        @(negedge clk);
        dv = 1'b0;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
